// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_pkg : shared state encoding and count-width helper | rev 1.0        |
// +--------------------------------------------------------------------------+
package fifo_pkg;

  localparam int BEATS = 8;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic int cnt_width(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_word_packer_word_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | word_shift_reg : beat insert (MSB/LSB order) and flush align | rev 1.0   |
// +--------------------------------------------------------------------------+
module word_shift_reg
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = BEATS,
  parameter int MSB_FIRST = 1,
  parameter int CW        = cnt_width(BEATS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 load,
  input  logic                 align,
  input  logic [IN_WIDTH-1:0]  beat,
  input  logic [CW-1:0]        captured,
  output logic [OUT_WIDTH-1:0] word
);

  localparam int c_nb = OUT_WIDTH / IN_WIDTH;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word <= '0;
        end else if (clear) begin
          word <= '0;
        end else if (align) begin
          // Partial word sits in the low bits; move it up so beat 0 is at the top.
          for (int b = 1; b < c_nb; b++) begin
            if (captured == CW'(b)) word <= word << ((c_nb - b) * IN_WIDTH);
          end
        end else if (load) begin
          word <= {word[OUT_WIDTH-IN_WIDTH-1:0], beat};
        end
      end
    end else begin : g_lsb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word <= '0;
        end else if (clear) begin
          word <= '0;
        end else if (align) begin
          word <= word;  // already packed from bit 0 with zero upper bits
        end else if (load) begin
          for (int b = 0; b < c_nb; b++) begin
            if (captured == CW'(b)) word[b*IN_WIDTH +: IN_WIDTH] <= beat;
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fifo_word_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_word_packer : packs FIFO beats into words on valid/ready | rev 1.0  |
// +--------------------------------------------------------------------------+
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int IN_WIDTH  = 1,
  parameter int OUT_WIDTH = BEATS,
  parameter int MSB_FIRST = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       fifo_empty,
  input  logic [IN_WIDTH-1:0]                        fifo_data,
  output logic                                       fifo_rd_en,
  input  logic                                       flush,
  output logic [OUT_WIDTH-1:0]                       out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic                                       out_partial,
  output logic [cnt_width(OUT_WIDTH/IN_WIDTH)-1:0]   out_beats
);

  localparam int            c_nb   = OUT_WIDTH / IN_WIDTH;
  localparam int            c_cw   = cnt_width(c_nb);
  localparam logic [c_cw-1:0] c_one  = c_cw'(1);
  localparam logic [c_cw-1:0] c_full = c_cw'(c_nb);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [c_cw-1:0]   r_issued;
  logic [c_cw-1:0]   r_captured;
  logic [c_cw-1:0]   w_cap_next;
  logic              r_rd_pend;
  logic              r_flush_latched;
  logic              w_full;
  logic              w_flush_go;
  logic              w_emit_part;
  logic              w_load;
  logic              w_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    fifo_rd_en  = 1'b0;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_full      = 1'b0;
    w_flush_go  = 1'b0;
    w_emit_part = 1'b0;
    w_cap_next  = r_rd_pend ? (r_captured + c_one) : r_captured;
    case (r_state)
      FILL: begin
        fifo_rd_en  = !fifo_empty && (r_issued < c_full) && !r_flush_latched;
        w_load      = r_rd_pend;
        w_full      = (w_cap_next == c_full);
        // A flush resolves only once the last in-flight beat has landed.
        w_flush_go  = r_flush_latched && !r_rd_pend;
        w_emit_part = w_flush_go && (r_captured != '0);
        if (w_full || w_emit_part) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_clear = out_ready;
        if (out_ready) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issued        <= '0;
      r_captured      <= '0;
      r_rd_pend       <= 1'b0;
      r_flush_latched <= 1'b0;
      out_valid       <= 1'b0;
      out_partial     <= 1'b0;
      out_beats       <= '0;
    end else if (w_clear) begin
      r_issued        <= '0;
      r_captured      <= '0;
      r_rd_pend       <= 1'b0;
      r_flush_latched <= 1'b0;
      out_valid       <= 1'b0;
      out_partial     <= 1'b0;
      out_beats       <= '0;
    end else if (r_state == FILL) begin
      r_rd_pend  <= fifo_rd_en;
      r_captured <= w_cap_next;
      if (fifo_rd_en) r_issued <= r_issued + c_one;
      if (w_full) begin
        // A full word wins over any flush arriving in the same cycle.
        out_valid       <= 1'b1;
        out_partial     <= 1'b0;
        out_beats       <= c_full;
        r_flush_latched <= 1'b0;
      end else if (w_flush_go) begin
        r_flush_latched <= 1'b0;
        if (w_emit_part) begin
          out_valid   <= 1'b1;
          out_partial <= 1'b1;
          out_beats   <= r_captured;
        end
      end else if (flush) begin
        r_flush_latched <= 1'b1;
      end
    end
  end

  word_shift_reg #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        (c_cw)
  ) u_word (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (w_clear),
    .load     (w_load),
    .align    (w_emit_part),
    .beat     (fifo_data),
    .captured (r_captured),
    .word     (out_data)
  );

endmodule
`default_nettype wire
